// File: rtl/sea_round_sched.sv
// Sequencer for an iterative SEA round datapath: holds L/R/K, drives one shared
// external round/key-update stage for NR cycles, and hands the result back with valid/ready.
module sea_round_sched #(
  parameter int unsigned NR = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_dec,
  input  logic [47:0]   in_l,
  input  logic [47:0]   in_r,
  input  logic [47:0]   in_k,
  output logic [47:0]   rf_li,
  output logic [47:0]   rf_ri,
  output logic [47:0]   rf_ki,
  output logic          rf_dec,
  output logic          rf_mid,
  input  logic [47:0]   rf_lo,
  input  logic [47:0]   rf_ro,
  input  logic [47:0]   kf_ko,
  output logic [CW-1:0] rnd_idx,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [47:0]   out_l,
  output logic [47:0]   out_r
);

  localparam int unsigned HW = 48;
  localparam logic [CW-1:0] LAST    = CW'(NR - 1);
  localparam logic [CW-1:0] MID_ENC = CW'(NR / 2 - 1);
  localparam logic [CW-1:0] MID_DEC = CW'(NR - NR / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] l_q, l_d, r_q, r_d, k_q, k_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          dec_q, dec_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          mid_q, mid_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      dec_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mid_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      dec_q       <= dec_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      mid_q       <= mid_d;
    end
  end

  // Next-state logic; flag outputs are decoded from the next state so they stay registered
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    k_d     = k_q;
    idx_d   = idx_q;
    dec_d   = dec_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = in_l;
          r_d     = in_r;
          k_d     = in_k;
          dec_d   = in_dec;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d = rf_lo;
        r_d = rf_ro;
        k_d = kf_ko;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    mid_d       = (state_d == RUN) && (idx_d == (dec_d ? MID_DEC : MID_ENC));
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign rf_mid    = mid_q;
  assign rf_dec    = dec_q;
  assign rnd_idx   = idx_q;
  assign rf_li     = l_q;
  assign rf_ri     = r_q;
  assign rf_ki     = k_q;
  assign out_l     = l_q;
  assign out_r     = r_q;

endmodule

// File: tb/tb_sea_round_sched.sv
// Directed bench for sea_round_sched: an NR=4 and an NR=3 instance, each closed
// through the stub round stage lo=ri, ro=li^ki, ko=ki.
module tb_sea_round_sched;

  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic        in_valid[2], in_ready[2], in_dec[2], rf_dec[2], rf_mid[2];
  logic        busy[2], out_valid[2], out_ready[2];
  logic [47:0] in_l[2], in_r[2], in_k[2], rf_li[2], rf_ri[2], rf_ki[2], out_l[2], out_r[2];
  logic [CW-1:0] rnd_idx[2];

  int n_vec = 0;
  int n_bad = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  sea_round_sched #(.NR(4), .CW(CW)) u_nr4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_dec(in_dec[0]),
    .in_l(in_l[0]), .in_r(in_r[0]), .in_k(in_k[0]),
    .rf_li(rf_li[0]), .rf_ri(rf_ri[0]), .rf_ki(rf_ki[0]),
    .rf_dec(rf_dec[0]), .rf_mid(rf_mid[0]),
    .rf_lo(rf_ri[0]), .rf_ro(rf_li[0] ^ rf_ki[0]), .kf_ko(rf_ki[0]),
    .rnd_idx(rnd_idx[0]), .busy(busy[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_l(out_l[0]), .out_r(out_r[0])
  );

  sea_round_sched #(.NR(3), .CW(CW)) u_nr3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_dec(in_dec[1]),
    .in_l(in_l[1]), .in_r(in_r[1]), .in_k(in_k[1]),
    .rf_li(rf_li[1]), .rf_ri(rf_ri[1]), .rf_ki(rf_ki[1]),
    .rf_dec(rf_dec[1]), .rf_mid(rf_mid[1]),
    .rf_lo(rf_ri[1]), .rf_ro(rf_li[1] ^ rf_ki[1]), .kf_ko(rf_ki[1]),
    .rnd_idx(rnd_idx[1]), .busy(busy[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_l(out_l[1]), .out_r(out_r[1])
  );

  // in_ready and busy must never be high together
  always @(negedge clk) begin
    if ((in_ready[0] && busy[0]) || (in_ready[1] && busy[1])) viol++;
  end

  typedef struct {
    int          d;
    logic        dec;
    logic [47:0] l, r, k, el, er;
    int          mid;
  } vec_t;

  vec_t tbl[6];

  localparam logic [47:0] A = 48'h123456789ABC;
  localparam logic [47:0] B = 48'h0F0F0F0F0F0F;
  localparam logic [47:0] K = 48'hFFFF00000000;

  function automatic int nr_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input int d, input logic dec, input logic [47:0] l, r, k, input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready[d]), 64'd1);
    in_valid[d] = 1'b1; in_dec[d] = dec; in_l[d] = l; in_r[d] = r; in_k[d] = k;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Called on the first negedge after accept; returns on the first negedge with out_valid
  task automatic wait_done(input int d, input logic dec, input int mid, input string tag);
    int lat = 0;
    int b_idx = 0, b_mid = 0, b_dec = 0, b_busy = 0;
    while (!out_valid[d] && lat < 300) begin
      if (rnd_idx[d] != CW'(lat)) b_idx++;
      if (rf_mid[d] != (lat == mid)) b_mid++;
      if (rf_dec[d] != dec) b_dec++;
      if (!busy[d] || in_ready[d]) b_busy++;
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(nr_of(d)));
    chk({tag, "_rnd_idx_seq"}, 64'(b_idx), 64'd0);
    chk({tag, "_rf_mid"}, 64'(b_mid), 64'd0);
    chk({tag, "_rf_dec"}, 64'(b_dec), 64'd0);
    chk({tag, "_run_flags"}, 64'(b_busy), 64'd0);
  endtask

  task automatic chk_out(input int d, input logic [47:0] el, er, input string tag);
    chk({tag, "_out_l"}, 64'(out_l[d]), 64'(el));
    chk({tag, "_out_r"}, 64'(out_r[d]), 64'(er));
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_idle_in_ready"}, 64'(in_ready[d]), 64'd1);
    chk({tag, "_idle_out_valid"}, 64'(out_valid[d]), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy[d]), 64'd0);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, A, B, K, A, B, 1};
    tbl[1] = '{0, 1'b1, A, B, K, A, B, 1};
    tbl[2] = '{1, 1'b0, A, B, K, 48'hF0F00F0F0F0F, A, 0};
    tbl[3] = '{1, 1'b1, A, B, K, 48'hF0F00F0F0F0F, A, 1};
    tbl[4] = '{0, 1'b0, 48'h0, 48'h0, 48'hFFFFFFFFFFFF, 48'h0, 48'h0, 1};
    tbl[5] = '{1, 1'b0, 48'h1, 48'h2, 48'h4, 48'h6, 48'h1, 0};

    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_dec[d] = 1'b0; out_ready[d] = 1'b1;
      in_l[d] = '0; in_r[d] = '0; in_k[d] = '0;
    end

    // Reset state
    #1 rst = 1'b1;
    #10;
    for (int d = 0; d < 2; d++) begin
      chk_idle(d, $sformatf("rst%0d", d));
      chk($sformatf("rst%0d_rf_mid", d), 64'(rf_mid[d]), 64'd0);
      chk($sformatf("rst%0d_rf_li", d), 64'(rf_li[d]), 64'd0);
      chk($sformatf("rst%0d_rnd_idx", d), 64'(rnd_idx[d]), 64'd0);
    end
    @(negedge clk) rst = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      string tag = $sformatf("v%0d", i);
      start(tbl[i].d, tbl[i].dec, tbl[i].l, tbl[i].r, tbl[i].k, tag);
      wait_done(tbl[i].d, tbl[i].dec, tbl[i].mid, tag);
      chk_out(tbl[i].d, tbl[i].el, tbl[i].er, tag);
      @(negedge clk);
      chk_idle(tbl[i].d, tag);
    end

    // Backpressure: result held for 5 cycles in DONE
    out_ready[1] = 1'b0;
    start(1, 1'b0, A, B, K, "bp");
    wait_done(1, 1'b0, 0, "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", c), 64'(out_valid[1]), 64'd1);
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready[1]), 64'd0);
      chk_out(1, 48'hF0F00F0F0F0F, A, $sformatf("bp%0d", c));
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk_idle(1, "bp_release");

    // Busy rejection: a block offered mid-RUN is not sampled
    start(1, 1'b0, A, B, K, "rej");
    in_valid[1] = 1'b1; in_l[1] = 48'h1; in_r[1] = 48'h2; in_k[1] = 48'h4;
    @(negedge clk);
    in_valid[1] = 1'b0;
    for (int c = 0; c < 20 && !out_valid[1]; c++) @(negedge clk);
    chk("rej_out_valid", 64'(out_valid[1]), 64'd1);
    chk_out(1, 48'hF0F00F0F0F0F, A, "rej");
    @(negedge clk);
    @(negedge clk);
    chk_idle(1, "rej_after");
    start(1, 1'b0, 48'h1, 48'h2, 48'h4, "rej2");
    wait_done(1, 1'b0, 0, "rej2");
    chk_out(1, 48'h6, 48'h1, "rej2");

    // Reset mid-RUN at rnd_idx=2, between edges
    start(0, 1'b0, A, B, K, "mrst");
    @(negedge clk);
    @(negedge clk);
    chk("mrst_at_idx", 64'(rnd_idx[0]), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk_idle(0, "mrst");
    chk("mrst_rf_li", 64'(rf_li[0]), 64'd0);
    chk("mrst_rf_ri", 64'(rf_ri[0]), 64'd0);
    chk("mrst_rf_ki", 64'(rf_ki[0]), 64'd0);
    chk("mrst_rnd_idx", 64'(rnd_idx[0]), 64'd0);
    chk("mrst_rf_mid", 64'(rf_mid[0]), 64'd0);
    @(negedge clk) rst = 1'b0;
    start(0, 1'b0, 48'hABCDEF012345, 48'h555555555555, 48'h00FF00FF00FF, "mrst2");
    wait_done(0, 1'b0, 1, "mrst2");
    chk_out(0, 48'hABCDEF012345, 48'h555555555555, "mrst2");

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_valid[1] = 1'b1; in_dec[1] = 1'b0; in_l[1] = A; in_r[1] = B; in_k[1] = K;
    @(negedge clk);
    chk("b2b_busy", 64'(busy[1]), 64'd1);
    in_l[1] = 48'h1; in_r[1] = 48'h2; in_k[1] = 48'h4;
    wait_done(1, 1'b0, 0, "b2b1");
    chk_out(1, 48'hF0F00F0F0F0F, A, "b2b1");
    @(negedge clk);
    chk_idle(1, "b2b_gap");
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_done(1, 1'b0, 0, "b2b2");
    chk_out(1, 48'h6, 48'h1, "b2b2");
    @(negedge clk);
    chk_idle(1, "b2b_end");

    chk("ready_while_busy", 64'(viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sea_round_sched.md
Name: sea_round_sched

Overview:
- Sequencer for an iterative SEA round datapath (48-bit halves, 48-bit key).
- Accepts one block, encrypt or decrypt, per transaction with a valid/ready handshake.
- Holds L/R/K state registers and feeds one external combinational round stage per cycle for NR cycles; an external key-update stage advances the key.
- Presents the result with a valid/ready handshake.
- Sits between the host interface and the shared round/key-update logic, so one round unit serves both directions.

Parameters:
- NR, 4, number of rounds per block; legal range 2..255.
- CW, 8, round counter width; must satisfy 2^CW > NR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  host offers a block.
- in_ready  out  1  scheduler can accept a block.
- in_dec  in  1  0=encrypt, 1=decrypt; captured on accept.
- in_l  in  48  left half.
- in_r  in  48  right half.
- in_k  in  48  key.
- rf_li  out  48  round-stage left input (= L register).
- rf_ri  out  48  round-stage right input (= R register).
- rf_ki  out  48  round-stage key input (= K register).
- rf_dec  out  1  captured mode.
- rf_mid  out  1  high during the key-schedule midpoint round.
- rf_lo  in  48  round-stage left result (combinational).
- rf_ro  in  48  round-stage right result.
- kf_ko  in  48  key-update result for rf_ki.
- rnd_idx  out  CW  current round index, 0..NR-1.
- busy  out  1  high in RUN or DONE.
- out_valid  out  1  result available.
- out_ready  in  1  host takes the result.
- out_l  out  48  result left (= L register).
- out_r  out  48  result right (= R register).

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE; L, R, K = 0; rnd_idx=0; mode=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, rf_mid=0.
  - Any in-flight block is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: L<=in_l, R<=in_r, K<=in_k, mode<=in_dec, rnd_idx<=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: L<=rf_lo, R<=rf_ro, K<=kf_ko, rnd_idx<=rnd_idx+1.
  - When rnd_idx==NR-1, the update still occurs, then go to DONE and rnd_idx<=0.
  - Exactly NR round cycles.
- rf_mid: high only in RUN when rnd_idx==floor(NR/2)-1 (encrypt) or rnd_idx==NR-floor(NR/2)-1 (decrypt). Never high outside RUN.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - L, R, K hold while out_ready=0; out_l, out_r stable under backpressure.
  - On out_ready: go to IDLE.
  - No same-cycle bypass: a new accept is possible no earlier than the cycle after the output handshake.
- Latency: accept at edge E0; out_valid=1 after edge E0+NR; result leaves on the first edge with out_ready=1 from then on.
- in_valid while in_ready=0 is ignored; inputs are not sampled.
- out_ready while out_valid=0 has no effect.
- rf_li, rf_ri, rf_ki always reflect the registers, including in IDLE and DONE; the round stage output is only consumed in RUN.
- rnd_idx increment never wraps within a block, because NR < 2^CW.

Test Plan:
Test bench round stub for all scenarios: rf_lo=rf_ri, rf_ro=rf_li^rf_ki, kf_ko=rf_ki.
- Basic encrypt, NR=4: in_l=48'h123456789ABC, in_r=48'h0F0F0F0F0F0F, in_k=48'hFFFF00000000, out_ready=1 -> out_valid exactly 4 cycles after accept; out_l=48'h123456789ABC, out_r=48'h0F0F0F0F0F0F; rnd_idx sequence 0,1,2,3; rf_mid high only at rnd_idx=1.
- NR=3, same inputs -> out_l=48'hF0F00F0F0F0F, out_r=48'h123456789ABC after 3 cycles; encrypt rf_mid at rnd_idx=0; repeat with in_dec=1 -> rf_mid at rnd_idx=1, rf_dec=1 throughout RUN.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_l/out_r unchanged, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
- Busy rejection: pulse in_valid with different data during RUN -> ignored; result equals the first block; the second block is accepted only after returning to IDLE.
- Reset mid-operation: assert rst at rnd_idx=2 (asynchronous, between edges) -> immediately busy=0, out_valid=0, in_ready=1, L/R/K=0; a following fresh block completes with correct values.
- Back-to-back: in_valid held high with two blocks -> second accept on the cycle after the first output handshake; each result correct; in_ready never high while busy.
